// File: rtl/iob_wishbone_bridge_buffered_pkg.sv
// Shared definitions for the buffered IOb-to-Wishbone bridge: FSM encoding and request-record layout.
// Record layout, MSB to LSB: {addr, wdata, wstrb}.
package iob_wb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUS  = 1'b1;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int REQ_W      = DEF_ADDR_W + DEF_DATA_W + DEF_DATA_W / 8;

  function automatic int req_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  function automatic int strb_lsb(input int data_w);
    return 0 * data_w;
  endfunction

  function automatic int data_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_wishbone_bridge_buffered_if.sv
// IOb request/response plus Wishbone classic signals of the bridge, grouped as one bundle.
// The slave modport is the bridge's view; the master modport is the CPU/peripheral environment.
interface iob_wishbone_bridge_buffered_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  valid_i;
  logic [ADDR_W-1:0]     address_i;
  logic [DATA_W-1:0]     wdata_i;
  logic [DATA_W/8-1:0]   wstrb_i;
  logic                  ready_o;
  logic                  rvalid_o;
  logic [DATA_W-1:0]     rdata_o;
  logic                  rerr_o;
  logic                  busy_o;
  logic [ADDR_W-1:0]     wb_addr_o;
  logic [DATA_W/8-1:0]   wb_select_o;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic [DATA_W-1:0]     wb_data_o;
  logic                  wb_ack_i;
  logic                  wb_error_i;
  logic [DATA_W-1:0]     wb_data_i;

  modport slave (
    input  valid_i, address_i, wdata_i, wstrb_i, wb_ack_i, wb_error_i, wb_data_i,
    output ready_o, rvalid_o, rdata_o, rerr_o, busy_o,
    output wb_addr_o, wb_select_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_data_o
  );

  modport master (
    output valid_i, address_i, wdata_i, wstrb_i, wb_ack_i, wb_error_i, wb_data_i,
    input  ready_o, rvalid_o, rdata_o, rerr_o, busy_o,
    input  wb_addr_o, wb_select_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_data_o
  );
endinterface

// File: rtl/iob_wishbone_bridge_buffered_req_fifo.sv
// Register FIFO for bridge requests; head is readable combinationally, push/pop take effect next edge.
// Push is dropped while full, pop while empty; pointers carry an extra wrap bit.
module iob2wb_req_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q;
  logic [DEPTH_LOG2:0]   rd_ptr_q;
  logic                  do_push;
  logic                  do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                      (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign do_push    = push_i & ~full_o;
  assign do_pop     = pop_i & ~empty_o;
  assign head_dat_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (DEPTH_LOG2 + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (DEPTH_LOG2 + 1)'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= push_dat_i;
  end
endmodule

// File: rtl/iob_wishbone_bridge_buffered.sv
// Buffered IOb->Wishbone classic master: push-to-stb 2 cycles, end-of-cycle-to-rvalid 1 cycle.
// ready_o drops only while the request FIFO is full; the bus slave stalls via ack/err or timeout.
module iob_wishbone_bridge_buffered
  import iob_wb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2,
  parameter int TIMEOUT_W  = 8
) (
  input  logic clk_i,
  input  logic arst_i,
  iob_wishbone_bridge_buffered_if.slave bus
);
  localparam int SW = DATA_W / 8;
  localparam int RW = req_w(ADDR_W, DATA_W);
  localparam int CW = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  // The counter holds completed BUS cycles, so this value marks the last permitted one.
  localparam logic [CW-1:0] CNT_LAST = CW'((2 ** CW) - 2);

  logic            full, empty, push, pop;
  logic [RW-1:0]   push_dat, head_dat;
  logic [0:0]      state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [SW-1:0]   strb_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic            in_bus, we, timeout, done;

  assign push     = bus.valid_i & ~full;
  assign pop      = (state_q == ST_IDLE) & ~empty;
  assign push_dat = {bus.address_i, bus.wdata_i, bus.wstrb_i};

  iob2wb_req_fifo #(.WIDTH(RW), .DEPTH_LOG2(DEPTH_LOG2)) u_req_fifo (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign in_bus  = (state_q == ST_BUS);
  assign we      = |strb_q;
  assign timeout = (TIMEOUT_W > 0) && in_bus && (cnt_q == CNT_LAST);
  assign done    = in_bus & (bus.wb_ack_i | bus.wb_error_i | timeout);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = done;
    rerr_d   = done & (bus.wb_error_i | timeout);
    rdata_d  = '0;
    if (pop) begin
      state_d = ST_BUS;
      cnt_d   = '0;
    end else if (done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (in_bus) begin
      cnt_d   = cnt_q + CW'(1);
    end
    // Error or timeout suppresses data even when ack arrives in the same cycle.
    if (done && bus.wb_ack_i && !bus.wb_error_i && !timeout && !we) rdata_d = bus.wb_data_i;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
      if (pop) begin
        addr_q <= head_dat[addr_lsb(DATA_W) +: ADDR_W];
        data_q <= head_dat[data_lsb(DATA_W) +: DATA_W];
        strb_q <= head_dat[strb_lsb(DATA_W) +: SW];
      end
    end
  end

  assign bus.ready_o     = ~full;
  assign bus.busy_o      = ~empty | in_bus | rvalid_q;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rdata_o     = rdata_q;
  assign bus.rerr_o      = rerr_q;
  assign bus.wb_cyc_o    = in_bus;
  assign bus.wb_stb_o    = in_bus;
  assign bus.wb_we_o     = in_bus & we;
  assign bus.wb_select_o = in_bus ? (we ? strb_q : {SW{1'b1}}) : '0;
  assign bus.wb_addr_o   = addr_q;
  assign bus.wb_data_o   = data_q;
endmodule

// File: tb/tb_iob_wishbone_bridge_buffered.sv
// Bench for the buffered IOb-to-Wishbone bridge: directed and random requests against a
// queue-based request/response model and a scripted Wishbone slave.
`timescale 1ns/1ps
module tb_iob_wishbone_bridge_buffered;
  localparam int AW = 32, DW = 32, DL2 = 2, TW = 3;
  localparam int DEPTH  = 1 << DL2;
  localparam int TO_LEN = (1 << TW) - 1;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_HANG = 3;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; } req_t;
  typedef struct { int mode; int dly; logic [31:0] rdata; } cfg_t;
  typedef struct { int len; logic err; logic [31:0] rdata; } rsp_t;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  req_t exp_q[$];
  cfg_t cfg_q[$];
  rsp_t rsp_q[$];

  iob_wishbone_bridge_buffered_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  iob_wishbone_bridge_buffered #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL2), .TIMEOUT_W(TW)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scripted Wishbone slave: each bus cycle takes the next cfg entry and records the response it implies.
  cfg_t cur;
  int   scnt = 0;
  logic active = 1'b0, late = 1'b0;
  always begin
    @(posedge clk); #1;
    bus.wb_ack_i   = 1'b0;
    bus.wb_error_i = 1'b0;
    bus.wb_data_i  = $urandom;
    if (arst) begin
      active = 1'b0; late = 1'b0; scnt = 0;
    end else begin
      if (late) begin
        bus.wb_ack_i = 1'b1;
        late = 1'b0;
      end
      if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (!active) begin
          active = 1'b1; scnt = 0;
          chk("slave_cfg_avail", cfg_q.size() > 0, 1);
          if (cfg_q.size() > 0) cur = cfg_q.pop_front();
          else cur = cfg_t'{M_ACK, 1, 32'h0};
        end
        scnt++;
        if (cur.mode == M_HANG) begin
          if (scnt == TO_LEN) begin
            rsp_q.push_back(rsp_t'{scnt, 1'b1, 32'h0});
            active = 1'b0;
            late = 1'b1;
          end
        end else if (scnt >= cur.dly) begin
          bus.wb_ack_i   = (cur.mode != M_ERR);
          bus.wb_error_i = (cur.mode != M_ACK);
          if (cur.mode == M_ACK) begin
            bus.wb_data_i = cur.rdata;
            rsp_q.push_back(rsp_t'{scnt, 1'b0, bus.wb_we_o ? 32'h0 : cur.rdata});
          end else begin
            rsp_q.push_back(rsp_t'{scnt, 1'b1, 32'h0});
          end
          active = 1'b0;
        end
      end
    end
  end

  // Monitor: FIFO occupancy model, issue order, timing of start/response, ready/busy.
  int   fifo_cnt = 0, len = 0;
  logic pend_push = 1'b0, exp_start = 1'b0, cyc_prev = 1'b0, stb_prev = 1'b0, exp_rv;
  req_t mon_e;
  rsp_t mon_r;
  always @(negedge clk) begin
    if (arst) begin
      fifo_cnt = 0; len = 0; pend_push = 1'b0; exp_start = 1'b0; cyc_prev = 1'b0; stb_prev = 1'b0;
    end else begin
      if (pend_push) fifo_cnt++;
      if (!cyc_prev) chk("cyc_start_timing", bus.wb_cyc_o, exp_start);
      if (bus.wb_cyc_o && !cyc_prev) begin
        fifo_cnt--;
        len = 0;
        chk("issue_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("wb_addr", bus.wb_addr_o, mon_e.addr);
          chk("wb_we", bus.wb_we_o, |mon_e.wstrb);
          chk("wb_select", bus.wb_select_o, (mon_e.wstrb == 4'h0) ? 4'hF : mon_e.wstrb);
          if (mon_e.wstrb != 4'h0) chk("wb_wdata", bus.wb_data_o, mon_e.wdata);
        end
      end
      if (bus.wb_stb_o) len++;
      exp_rv = stb_prev && !bus.wb_stb_o;
      chk("rvalid_timing", bus.rvalid_o, exp_rv);
      if (bus.rvalid_o) begin
        chk("rsp_avail", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
          mon_r = rsp_q.pop_front();
          chk("rdata", bus.rdata_o, mon_r.rdata);
          chk("rerr", bus.rerr_o, mon_r.err);
          chk("bus_cycle_len", len, mon_r.len);
          chk("cyc_low_at_rvalid", bus.wb_cyc_o, 0);
        end
      end
      chk("ready", bus.ready_o, fifo_cnt < DEPTH);
      chk("busy", bus.busy_o, (fifo_cnt > 0) || bus.wb_stb_o || exp_rv);
      exp_start = !bus.wb_cyc_o && (fifo_cnt > 0);
      pend_push = bus.valid_i && bus.ready_o;
      cyc_prev  = bus.wb_cyc_o;
      stb_prev  = bus.wb_stb_o;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int mode, input int dly, input logic [31:0] rd);
    int n = 0;
    bus.valid_i = 1'b1; bus.address_i = a; bus.wdata_i = d; bus.wstrb_i = s;
    while (n < 200) begin
      @(negedge clk);
      if (bus.ready_o) break;
      n++;
    end
    chk("send_accept_timeout", n < 200, 1);
    exp_q.push_back(req_t'{a, d, s});
    cfg_q.push_back(cfg_t'{mode, dly, rd});
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus.busy_o || exp_q.size() > 0 || rsp_q.size() > 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_idle_timeout"}, n < 400, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.valid_i = 1'b0; bus.address_i = '0; bus.wdata_i = '0; bus.wstrb_i = '0;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_cyc", bus.wb_cyc_o, 0);
    chk("rst_stb", bus.wb_stb_o, 0);
    chk("rst_we", bus.wb_we_o, 0);
    chk("rst_sel", bus.wb_select_o, 0);
    chk("rst_addr", bus.wb_addr_o, 0);
    chk("rst_wdata", bus.wb_data_o, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_rerr", bus.rerr_o, 0);
    arst = 1'b0;
    @(posedge clk); #1;

    // Single read, ack on the third strobe cycle.
    send(32'h10, $urandom, 4'h0, M_ACK, 3, 32'hDEADBEEF);
    wait_idle("single_read");

    // Burst of five writes fills the FIFO while the first is on the bus.
    for (int i = 0; i < 5; i++)
      send(32'h100 + 32'(4 * i), $urandom, 4'($urandom_range(1, 15)), M_ACK, 3, 32'h0);
    @(negedge clk);
    chk("ready_low_when_full", bus.ready_o, 0);
    wait_idle("write_burst");

    // Slave error, then ack and error together.
    send(32'h200, $urandom, 4'h0, M_ERR, 2, 32'h0);
    send(32'h204, $urandom, 4'h0, M_BOTH, 1, 32'h0);
    wait_idle("errors");

    // Hung slave times out; the following request completes normally despite a late ack.
    send(32'h300, $urandom, 4'h0, M_HANG, 1, 32'h0);
    send(32'h304, $urandom, 4'h0, M_ACK, 2, 32'hCAFE0123);
    wait_idle("timeout");

    // Random traffic with back-to-back pushes keeps the FIFO saturated.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] s;
      int r, m;
      r = $urandom_range(0, 3);
      s = (r == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      r = $urandom_range(0, 7);
      m = (r == 0) ? M_ERR : ((r == 1) ? M_BOTH : M_ACK);
      send($urandom & 32'hFFFF_FFFC, $urandom, s, m, $urandom_range(1, 5), $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_idle("random");

    // Reset while a bus cycle is open and three requests are queued.
    send(32'h400, $urandom, 4'h0, M_HANG, 1, 32'h0);
    send(32'h404, $urandom, 4'h0, M_ACK, 1, 32'h0);
    send(32'h408, $urandom, 4'hF, M_ACK, 1, 32'h0);
    send(32'h40C, $urandom, 4'h0, M_ACK, 1, 32'h0);
    @(posedge clk); #3;
    arst = 1'b1;
    exp_q.delete(); cfg_q.delete(); rsp_q.delete();
    #1;
    chk("rst_mid_cyc", bus.wb_cyc_o, 0);
    chk("rst_mid_stb", bus.wb_stb_o, 0);
    chk("rst_mid_rvalid", bus.rvalid_o, 0);
    repeat (2) @(posedge clk);
    #3;
    arst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.ready_o, 1);
    chk("post_rst_busy", bus.busy_o, 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    send(32'h500, $urandom, 4'h0, M_ACK, 2, 32'h1234_5678);
    wait_idle("recovery");

    chk("exp_q_drained", exp_q.size(), 0);
    chk("cfg_q_drained", cfg_q.size(), 0);
    chk("rsp_q_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
